// File: rtl/bc_pkg.sv
// Shared types for the Bulls & Cows engine: FSM state encoding, display glyph
// codes and the digit-to-glyph mapping used by the display renderer.
package bc_pkg;

    localparam int GW = 6;

    typedef logic [GW-1:0] glyph_t;

    typedef enum logic [2:0] {
        ST_SECRET = 3'd0,
        ST_GUESS  = 3'd1,
        ST_SCORE  = 3'd2,
        ST_SHOW   = 3'd3,
        ST_WIN    = 3'd4,
        ST_DRAW   = 3'd5
    } state_t;

    // Glyphs 0..9 are the digits themselves; letters follow from 10 upward.
    localparam glyph_t G_S     = 6'd10;
    localparam glyph_t G_E     = 6'd11;
    localparam glyph_t G_C_UP  = 6'd12;
    localparam glyph_t G_R_LO  = 6'd13;
    localparam glyph_t G_J     = 6'd14;
    localparam glyph_t G_B_LO  = 6'd15;
    localparam glyph_t G_C_LO  = 6'd16;
    localparam glyph_t G_W     = 6'd17;
    localparam glyph_t G_I     = 6'd18;
    localparam glyph_t G_N     = 6'd19;
    localparam glyph_t G_D     = 6'd20;
    localparam glyph_t G_A     = 6'd21;
    localparam glyph_t G_BLANK = 6'h3F;

    function automatic glyph_t glyph_of_digit(input logic [7:0] d);
        return (d <= 8'd9) ? glyph_t'(d) : G_BLANK;
    endfunction

endpackage

// File: rtl/bulls_cows_engine_if.sv
// Front-panel bus between switches/button, the engine and the display driver.
interface bulls_cows_engine_if #(
    parameter int N_DIGITS = 4,
    parameter int DIGIT_W  = 4,
    parameter int N_DISP   = 8,
    parameter int GLYPH_W  = 6
);
    // confirm is a debounced level; only its rising edge means "take sw now".
    // sw must be stable from that edge until two clocks later; disp is a
    // free-running registered output with no handshake.
    logic                        confirm;
    logic [N_DIGITS*DIGIT_W-1:0] sw;
    logic [N_DISP*GLYPH_W-1:0]   disp;

    modport master (output confirm, output sw, input disp);
    modport slave  (input confirm, input sw, output disp);
endinterface

// File: rtl/bc_scorer.sv
// Combinational bulls/cows counter for one guess against one secret.
module bc_scorer #(
    parameter int N_DIGITS = 4,
    parameter int DIGIT_W  = 4
) (
    input  logic [N_DIGITS*DIGIT_W-1:0]  guess_i,
    input  logic [N_DIGITS*DIGIT_W-1:0]  secret_i,
    output logic [$clog2(N_DIGITS+1)-1:0] bulls_o,
    output logic [$clog2(N_DIGITS+1)-1:0] cows_o
);
    localparam int NW = $clog2(N_DIGITS + 1);

    always_comb begin
        bulls_o = '0;
        cows_o  = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            for (int j = 0; j < N_DIGITS; j++) begin
                if (guess_i[i*DIGIT_W +: DIGIT_W] == secret_i[j*DIGIT_W +: DIGIT_W]) begin
                    if (i == j) bulls_o = bulls_o + NW'(1);
                    else        cows_o  = cows_o + NW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/bulls_cows_engine.sv
// Bulls & Cows game controller: secret entry, guessing, scoring, win detection.
// Optional macro BC_ATTEMPT_LIMIT_EN adds per-player try limits and a draw state.
module bulls_cows_engine
    import bc_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int DIGIT_W   = 4,
    parameter int MAX_DIGIT = 9,
    parameter int N_PLAYERS = 2,
    parameter int N_DISP    = 8,
    parameter int GLYPH_W   = 6,
    parameter int MAX_TRIES = 10
) (
    input  logic                           clock,
    input  logic                           reset,
    bulls_cows_engine_if.slave             panel,
    output state_t                         state_o,
    output logic [$clog2(N_PLAYERS)-1:0]   player_o,
    output logic [$clog2(N_DIGITS+1)-1:0]  bulls_o,
    output logic [$clog2(N_DIGITS+1)-1:0]  cows_o,
    output logic                           reject_o,
    output logic                           win_o
`ifdef BC_ATTEMPT_LIMIT_EN
    ,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_o
`endif
);
    localparam int CW = N_DIGITS * DIGIT_W;
    localparam int PW = $clog2(N_PLAYERS);
    localparam int NW = $clog2(N_DIGITS + 1);
    localparam int DW = N_DISP * GLYPH_W;

    typedef logic [CW-1:0] code_t;

    if (N_PLAYERS < 2 || N_PLAYERS > 8 || MAX_TRIES < 1 || N_DISP < N_DIGITS + 2 || N_DISP < 6)
    begin : g_bad_cfg
        $error("bulls_cows_engine: unsupported parameter combination");
    end

    function automatic logic code_valid(input code_t c);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (c[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(MAX_DIGIT)) ok = 1'b0;
            for (int j = 0; j < N_DIGITS; j++) begin
                if (i != j && c[i*DIGIT_W +: DIGIT_W] == c[j*DIGIT_W +: DIGIT_W]) ok = 1'b0;
            end
        end
        return ok;
    endfunction

    function automatic logic [PW-1:0] next_player(input logic [PW-1:0] p);
        return (p == PW'(N_PLAYERS - 1)) ? '0 : p + PW'(1);
    endfunction

    // Position 0 is leftmost; code digits are shown most-significant first.
    function automatic logic [DW-1:0] render(input state_t st, input logic [PW-1:0] p,
                                             input code_t c, input logic [NW-1:0] b,
                                             input logic [NW-1:0] k);
        glyph_t          g [N_DISP];
        logic [DW-1:0]   packed_g;
        for (int i = 0; i < N_DISP; i++) g[i] = G_BLANK;
        case (st)
            ST_SECRET: begin
                g[0] = G_S; g[1] = G_E; g[2] = G_C_UP; g[3] = G_R_LO;
                g[4] = G_J; g[5] = glyph_of_digit(8'(p));
            end
            ST_GUESS: begin
                for (int i = 0; i < N_DIGITS; i++)
                    g[i] = glyph_of_digit(8'(c[(N_DIGITS-1-i)*DIGIT_W +: DIGIT_W]));
                g[N_DIGITS]   = G_J;
                g[N_DIGITS+1] = glyph_of_digit(8'(p));
            end
            ST_SHOW: begin
                g[0] = glyph_of_digit(8'(b)); g[1] = G_B_LO;
                g[2] = glyph_of_digit(8'(k)); g[3] = G_C_LO;
            end
            ST_WIN: begin
                g[0] = G_J; g[1] = glyph_of_digit(8'(p));
                g[2] = G_W; g[3] = G_I; g[4] = G_N;
            end
            ST_DRAW: begin
                g[0] = G_D; g[1] = G_R_LO; g[2] = G_A; g[3] = G_W;
            end
            default: ;
        endcase
        for (int i = 0; i < N_DISP; i++) packed_g[i*GLYPH_W +: GLYPH_W] = GLYPH_W'(g[i]);
        return packed_g;
    endfunction

    state_t          state_q, state_d;
    logic [PW-1:0]   player_q, player_d;
    logic            confirm_q, tick_q;
    logic            reject_q, reject_d;
    logic            store_secret;
    code_t           guess_q, guess_d;
    code_t           secret_q [N_PLAYERS];
    code_t           target_secret;
    logic [NW-1:0]   bulls_q, bulls_d, cows_q, cows_d;
    logic [NW-1:0]   sc_bulls, sc_cows;
    logic [DW-1:0]   disp_q, disp_d;

    assign target_secret = secret_q[next_player(player_q)];

    bc_scorer #(.N_DIGITS(N_DIGITS), .DIGIT_W(DIGIT_W)) u_scorer (
        .guess_i (guess_q),
        .secret_i(target_secret),
        .bulls_o (sc_bulls),
        .cows_o  (sc_cows)
    );

`ifdef BC_ATTEMPT_LIMIT_EN
    localparam int TW = $clog2(MAX_TRIES + 1);
    logic [TW-1:0] tries_q [N_PLAYERS];
    logic          all_used;

    always_comb begin
        all_used = 1'b1;
        for (int p = 0; p < N_PLAYERS; p++)
            if (tries_q[p] != TW'(MAX_TRIES)) all_used = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < N_PLAYERS; p++) tries_q[p] <= '0;
        end else if (state_q == ST_GUESS && state_d == ST_SCORE) begin
            tries_q[player_q] <= tries_q[player_q] + TW'(1);
        end
    end

    assign tries_o = tries_q[player_q];
`endif

    always_comb begin
        state_d      = state_q;
        player_d     = player_q;
        guess_d      = guess_q;
        bulls_d      = bulls_q;
        cows_d       = cows_q;
        reject_d     = 1'b0;
        store_secret = 1'b0;
        case (state_q)
            ST_SECRET: if (tick_q) begin
                if (code_valid(panel.sw)) begin
                    store_secret = 1'b1;
                    if (player_q == PW'(N_PLAYERS - 1)) begin
                        player_d = '0;
                        state_d  = ST_GUESS;
                    end else begin
                        player_d = player_q + PW'(1);
                    end
                end else begin
                    reject_d = 1'b1;
                end
            end
            ST_GUESS: if (tick_q) begin
                if (code_valid(panel.sw)) begin
                    guess_d = panel.sw;
                    state_d = ST_SCORE;
                end else begin
                    reject_d = 1'b1;
                end
            end
            // Ticks landing here are simply not looked at, so they are lost.
            ST_SCORE: begin
                bulls_d = sc_bulls;
                cows_d  = sc_cows;
                state_d = (sc_bulls == NW'(N_DIGITS)) ? ST_WIN : ST_SHOW;
            end
            ST_SHOW: if (tick_q) begin
`ifdef BC_ATTEMPT_LIMIT_EN
                if (all_used) begin
                    state_d = ST_DRAW;
                end else begin
                    state_d  = ST_GUESS;
                    player_d = next_player(player_q);
                end
`else
                state_d  = ST_GUESS;
                player_d = next_player(player_q);
`endif
            end
            ST_WIN, ST_DRAW: ;
            default: state_d = ST_SECRET;
        endcase
        disp_d = (state_q == ST_SCORE) ? disp_q
                                       : render(state_q, player_q, panel.sw, bulls_q, cows_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_SECRET;
            player_q  <= '0;
            confirm_q <= 1'b0;
            tick_q    <= 1'b0;
            reject_q  <= 1'b0;
            guess_q   <= '0;
            bulls_q   <= '0;
            cows_q    <= '0;
            for (int p = 0; p < N_PLAYERS; p++) secret_q[p] <= '0;
            disp_q    <= render(ST_SECRET, '0, '0, '0, '0);
        end else begin
            state_q   <= state_d;
            player_q  <= player_d;
            confirm_q <= panel.confirm;
            tick_q    <= panel.confirm & ~confirm_q;
            reject_q  <= reject_d;
            guess_q   <= guess_d;
            bulls_q   <= bulls_d;
            cows_q    <= cows_d;
            disp_q    <= disp_d;
            if (store_secret) secret_q[player_q] <= panel.sw;
        end
    end

    assign panel.disp = disp_q;
    assign state_o    = state_q;
    assign player_o   = player_q;
    assign bulls_o    = bulls_q;
    assign cows_o     = cows_q;
    assign reject_o   = reject_q;
    assign win_o      = (state_q == ST_WIN);

endmodule

// File: tb/tb_bulls_cows_engine.sv
// Directed bench for bulls_cows_engine; define BC_ATTEMPT_LIMIT_EN to add the draw scenario.
module tb_bulls_cows_engine;
    import bc_pkg::*;

`ifdef BC_ATTEMPT_LIMIT_EN
    localparam int MAX_TRIES = 2;
`else
    localparam int MAX_TRIES = 10;
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bulls_cows_engine_if #(.N_DIGITS(4), .DIGIT_W(4), .N_DISP(8), .GLYPH_W(6)) panel ();

    state_t     state_o;
    logic [0:0] player_o;
    logic [2:0] bulls_o, cows_o;
    logic       reject_o, win_o;
`ifdef BC_ATTEMPT_LIMIT_EN
    logic [1:0] tries_o;
`endif

    bulls_cows_engine #(.MAX_TRIES(MAX_TRIES)) dut (
        .clock   (clock),
        .reset   (reset),
        .panel   (panel),
        .state_o (state_o),
        .player_o(player_o),
        .bulls_o (bulls_o),
        .cows_o  (cows_o),
        .reject_o(reject_o),
`ifdef BC_ATTEMPT_LIMIT_EN
        .win_o   (win_o),
        .tries_o (tries_o)
`else
        .win_o   (win_o)
`endif
    );

    int n_asserts = 0;
    int n_fails   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] disp8(input glyph_t g0, input glyph_t g1, input glyph_t g2,
                                          input glyph_t g3, input glyph_t g4, input glyph_t g5,
                                          input glyph_t g6, input glyph_t g7);
        return {g7, g6, g5, g4, g3, g2, g1, g0};
    endfunction

    // Rising edge on confirm with sw held; returns on the falling edge after the FSM acted.
    task automatic press(input logic [15:0] code, input int hold);
        @(negedge clock);
        panel.sw      = code;
        panel.confirm = 1'b1;
        repeat (hold) @(negedge clock);
        panel.confirm = 1'b0;
    endtask

    initial begin
        panel.confirm = 1'b0;
        panel.sw      = '0;
        reset         = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        check("rst_state",  state_o,  ST_SECRET);
        check("rst_player", player_o, 1'b0);
        check("rst_bulls",  bulls_o,  3'd0);
        check("rst_cows",   cows_o,   3'd0);
        check("rst_reject", reject_o, 1'b0);
        check("rst_win",    win_o,    1'b0);
        check("rst_disp", panel.disp,
              disp8(G_S, G_E, G_C_UP, G_R_LO, G_J, 6'd0, G_BLANK, G_BLANK));

        press(16'h1124, 2);
        check("rej_dup",       reject_o, 1'b1);
        check("rej_dup_state", state_o,  ST_SECRET);
        check("rej_dup_player", player_o, 1'b0);
        @(negedge clock);
        check("rej_pulse_end", reject_o, 1'b0);
        press(16'h12A4, 2);
        check("rej_range", reject_o, 1'b1);

        press(16'h1234, 2);
        check("sec0_player", player_o, 1'b1);
        check("sec0_state",  state_o,  ST_SECRET);
        check("sec0_reject", reject_o, 1'b0);
        @(negedge clock);
        check("sec_banner_p1", panel.disp,
              disp8(G_S, G_E, G_C_UP, G_R_LO, G_J, 6'd1, G_BLANK, G_BLANK));

        press(16'h5678, 2);
        check("sec1_state",  state_o,  ST_GUESS);
        check("sec1_player", player_o, 1'b0);
        @(negedge clock);
        check("guess_disp_a", panel.disp,
              disp8(6'd5, 6'd6, 6'd7, 6'd8, G_J, 6'd0, G_BLANK, G_BLANK));
        panel.sw = 16'h9012;
        @(negedge clock);
        check("guess_disp_live", panel.disp,
              disp8(6'd9, 6'd0, 6'd1, 6'd2, G_J, 6'd0, G_BLANK, G_BLANK));

        press(16'h1233, 2);
        check("guess_rej",       reject_o, 1'b1);
        check("guess_rej_state", state_o,  ST_GUESS);

        press(16'h8765, 2);
        check("g8765_score", state_o, ST_SCORE);
        @(negedge clock);
        check("g8765_state", state_o, ST_SHOW);
        check("g8765_bulls", bulls_o, 3'd0);
        check("g8765_cows",  cows_o,  3'd4);
        @(negedge clock);
        check("show_disp", panel.disp,
              disp8(6'd0, G_B_LO, 6'd4, G_C_LO, G_BLANK, G_BLANK, G_BLANK, G_BLANK));

        press(16'h0000, 2);
        check("turn_state",  state_o,  ST_GUESS);
        check("turn_player", player_o, 1'b1);

        press(16'h1243, 50);
        check("held_state",  state_o,  ST_SHOW);
        check("held_player", player_o, 1'b1);
        check("g1243_bulls", bulls_o,  3'd2);
        check("g1243_cows",  cows_o,   3'd2);

        press(16'h0000, 2);
        check("wrap_player", player_o, 1'b0);
        check("wrap_state",  state_o,  ST_GUESS);

        press(16'h5613, 2);
        @(negedge clock);
        check("g5613_state", state_o, ST_SHOW);
        check("g5613_bulls", bulls_o, 3'd2);
        check("g5613_cows",  cows_o,  3'd0);

        reset = 1'b1;
        #1;
        check("midrst_state",  state_o,  ST_SECRET);
        check("midrst_player", player_o, 1'b0);
        check("midrst_bulls",  bulls_o,  3'd0);
        check("midrst_cows",   cows_o,   3'd0);
        check("midrst_disp", panel.disp,
              disp8(G_S, G_E, G_C_UP, G_R_LO, G_J, 6'd0, G_BLANK, G_BLANK));
        @(negedge clock);
        reset = 1'b0;

        press(16'h1234, 2);
        press(16'h5678, 2);
        press(16'h5678, 2);
        @(negedge clock);
        check("win_state", state_o, ST_WIN);
        check("win_flag",  win_o,   1'b1);
        check("win_bulls", bulls_o, 3'd4);
        check("win_cows",  cows_o,  3'd0);
        @(negedge clock);
        check("win_disp", panel.disp,
              disp8(G_J, 6'd0, G_W, G_I, G_N, G_BLANK, G_BLANK, G_BLANK));
        press(16'h1234, 2);
        repeat (3) @(negedge clock);
        check("win_hold_state", state_o, ST_WIN);
        check("win_hold_flag",  win_o,   1'b1);

`ifdef BC_ATTEMPT_LIMIT_EN
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("draw_rst_tries", tries_o, 2'd0);
        press(16'h1234, 2);
        press(16'h5678, 2);
        for (int k = 0; k < 4; k++) begin
            press((k % 2 == 0) ? 16'h9012 : 16'h9085, 2);
            @(negedge clock);
            check("draw_bulls", bulls_o, 3'd0);
            check("draw_cows",  cows_o,  3'd0);
            check("draw_tries", tries_o, 2'(k / 2 + 1));
            press(16'h0000, 2);
            if (k == 3) check("draw_state", state_o, ST_DRAW);
            else        check("draw_next",  state_o, ST_GUESS);
        end
        @(negedge clock);
        check("draw_disp", panel.disp,
              disp8(G_D, G_R_LO, G_A, G_W, G_BLANK, G_BLANK, G_BLANK, G_BLANK));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule
